icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and `mem_ctrl`. On a hit it returns the 32-bit instruction on the cycle after acceptance. On a miss it issues a single word fetch on `mem_ctrl`'s icache port, fills the line when the word returns, and forwards the word to fetch. It also absorbs pipeline flushes that arrive while a refill is in flight.

---
 rtl/icache.sv | 167 ++++++++++++++++
 tb/tb_icache.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and mem_ctrl.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    MISS
  } state_t;

  state_t state, state_n;

  logic                  deliver, deliver_n;
  logic                  inst_valid_n;
  logic [31:0]           inst_n;
  logic                  mem_req_n;
  logic [31:0]           mem_addr_n;
  logic [INDEX_BITS-1:0] miss_idx, miss_idx_n;
  logic [TAG_W-1:0]      miss_tag, miss_tag_n;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  lookup_hit;
  logic                  accept;
  logic                  acc_hit;
  logic                  acc_miss;
  logic                  fill;
  logic                  unused_addr_bits;

  assign req_idx    = fetch_addr[INDEX_BITS+1:2];
  assign req_tag    = fetch_addr[31:INDEX_BITS+2];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign accept     = (state == IDLE) && fetch_valid && !flush;
  assign acc_hit    = accept && lookup_hit;
  assign acc_miss   = accept && !lookup_hit;
  assign fill       = (state == MISS) && mem_ready;

  // Byte offset within the word never selects anything.
  assign unused_addr_bits = ^fetch_addr[1:0];

  always_comb begin
    state_n      = state;
    deliver_n    = deliver;
    inst_valid_n = 1'b0;
    inst_n       = inst;
    mem_req_n    = mem_req;
    mem_addr_n   = mem_addr;
    miss_idx_n   = miss_idx;
    miss_tag_n   = miss_tag;
    unique case (state)
      IDLE: begin
        if (acc_hit) begin
          inst_n       = data_q[req_idx];
          inst_valid_n = 1'b1;
          state_n      = RESP;
        end else if (acc_miss) begin
          mem_req_n  = 1'b1;
          mem_addr_n = {fetch_addr[31:2], 2'b00};
          miss_idx_n = req_idx;
          miss_tag_n = req_tag;
          deliver_n  = 1'b1;
          state_n    = MISS;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      MISS: begin
        if (mem_ready) begin
          mem_req_n = 1'b0;
          deliver_n = 1'b0;
          if (deliver && !flush) begin
            inst_n       = mem_data;
            inst_valid_n = 1'b1;
            state_n      = RESP;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // A redirect cancels whatever was owed to fetch.
    if (flush) begin
      deliver_n    = 1'b0;
      inst_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      deliver    <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      miss_idx   <= '0;
      miss_tag   <= '0;
      valid_q    <= '0;
    end else if (rdy) begin
      state      <= state_n;
      deliver    <= deliver_n;
      inst_valid <= inst_valid_n;
      inst       <= inst_n;
      mem_req    <= mem_req_n;
      mem_addr   <= mem_addr_n;
      miss_idx   <= miss_idx_n;
      miss_tag   <= miss_tag_n;
      if (fill) valid_q[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (rdy) begin
      if (acc_hit)  hit_q  <= hit_q + 32'd1;
      if (acc_miss) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cache-content model plus per-cycle output compare.
// Counter expectations follow ICACHE_STATS_EN.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, fetch_valid;
  logic [31:0] fetch_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] hit_count, miss_count;

  icache #(.INDEX_BITS(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .fetch_valid(fetch_valid),
    .fetch_addr (fetch_addr),
    .inst_valid (inst_valid),
    .inst       (inst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Cache contents as the bench believes them to be.
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  int unsigned m_hits, m_misses;

  logic        exp_iv, exp_req, chk_en;
  logic [31:0] exp_inst, exp_addr;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] exp_hits();
`ifdef ICACHE_STATS_EN
    return m_hits;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_misses();
`ifdef ICACHE_STATS_EN
    return m_misses;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    logic [5:0] idx;
    idx = a[7:2];
    return m_valid[idx] && (m_tag[idx] == a[31:8]);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    exp_iv   = 1'b0;
    exp_req  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("inst_valid", {31'd0, inst_valid}, {31'd0, exp_iv});
      check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      if (exp_iv) check("inst", inst, exp_inst);
      if (exp_req) check("mem_addr", mem_addr, exp_addr);
      check("hit_count", hit_count, exp_hits());
      check("miss_count", miss_count, exp_misses());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch; on a miss the memory answers k cycles after the request.
  task automatic fetch(input logic [31:0] a, input logic [31:0] word,
                       input int k, input int flush_at, input int pause,
                       output logic was_miss);
    logic [5:0] idx;
    logic       delivered;
    idx         = a[7:2];
    fetch_valid = 1'b1;
    fetch_addr  = a;
    if (model_hit(a)) begin
      was_miss = 1'b0;
      tick();
      fetch_valid = 1'b0;
      exp_iv      = 1'b1;
      exp_inst    = m_data[idx];
      m_hits++;
      tick();
      exp_iv = 1'b0;
    end else begin
      was_miss  = 1'b1;
      delivered = 1'b1;
      tick();
      exp_req  = 1'b1;
      exp_addr = {a[31:2], 2'b00};
      m_misses++;
      for (int i = 1; i < k; i++) begin
        if (i == 1 && pause > 0) begin
          rdy = 1'b0;
          repeat (pause) tick();
          rdy = 1'b1;
        end
        if (i == flush_at) begin
          flush       = 1'b1;
          fetch_valid = 1'b0;
          delivered   = 1'b0;
        end
        tick();
        flush = 1'b0;
      end
      mem_ready = 1'b1;
      mem_data  = word;
      tick();
      mem_ready    = 1'b0;
      exp_req      = 1'b0;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = a[31:8];
      m_data[idx]  = word;
      if (delivered) begin
        exp_iv      = 1'b1;
        exp_inst    = word;
        fetch_valid = 1'b0;
        tick();
        exp_iv = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    logic m;
    int   pulses;
    chk_en      = 1'b0;
    rst         = 1'b1;
    rdy         = 1'b1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    fetch_addr  = '0;
    mem_ready   = 1'b0;
    mem_data    = '0;
    exp_inst    = '0;
    exp_addr    = '0;
    clear_model();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset inst", inst, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    tick();

    // Cold miss then hit
    fetch(32'h0000_0004, 32'h00A0_0093, 5, 0, 0, m);
    check("cold miss", {31'd0, m}, 32'd1);
    fetch(32'h0000_0004, 32'h0, 1, 0, 0, m);
    check("refetch hit", {31'd0, m}, 32'd0);
    check("hit inst", inst, 32'h00A0_0093);

    // Conflict eviction on index 4
    fetch(32'h0000_0010, 32'h1111_1111, 3, 0, 0, m);
    fetch(32'h0000_0110, 32'h2222_2222, 2, 0, 0, m);
    check("conflict miss", {31'd0, m}, 32'd1);
    fetch(32'h0000_0010, 32'h1111_1111, 2, 0, 0, m);
    check("evicted miss", {31'd0, m}, 32'd1);

    // Flush while the refill is outstanding
    fetch(32'h0000_0020, 32'h3333_3333, 5, 2, 0, m);
    check("flush miss", {31'd0, m}, 32'd1);
    fetch(32'h0000_0020, 32'h0, 1, 0, 0, m);
    check("post-flush hit", {31'd0, m}, 32'd0);
    check("post-flush inst", inst, 32'h3333_3333);

    // Held request on a hit line: served every other cycle
    pulses      = 0;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0000_0004;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (inst_valid) pulses++;
      exp_iv   = (i % 2 == 0);
      exp_inst = 32'h00A0_0093;
      if (i % 2 == 0) m_hits++;
    end
    fetch_valid = 1'b0;
    exp_iv      = 1'b0;
    check("held pulses", pulses, 32'd2);
    tick();

    // Flush and request together: nothing accepted
    fetch_valid = 1'b1;
    flush       = 1'b1;
    tick();
    fetch_valid = 1'b0;
    flush       = 1'b0;
    check("flush wins", {31'd0, inst_valid}, 32'd0);
    tick();

    // Stall in the middle of a miss
    fetch(32'h0000_0030, 32'h4444_4444, 4, 0, 3, m);
    check("stall miss", {31'd0, m}, 32'd1);

    // Stall with a hit request presented
    rdy         = 1'b0;
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0000_0004;
    tick();
    tick();
    check("stalled hit", {31'd0, inst_valid}, 32'd0);
    fetch_valid = 1'b0;
    rdy         = 1'b1;
    tick();

    // Reset in the middle of a miss
    fetch_valid = 1'b1;
    fetch_addr  = 32'h0000_0040;
    tick();
    exp_req  = 1'b1;
    exp_addr = 32'h0000_0040;
    m_misses++;
    tick();
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    fetch_valid = 1'b0;
    clear_model();
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst inst_valid", {31'd0, inst_valid}, 32'd0);
    tick();

    // Stats sequence: 3 misses, 5 hits
    fetch(32'h0000_0004, 32'h00A0_0093, 2, 0, 0, m);
    check("after rst miss", {31'd0, m}, 32'd1);
    fetch(32'h0000_0004, 32'h0, 1, 0, 0, m);
    fetch(32'h0000_0008, 32'h5555_5555, 3, 0, 0, m);
    fetch(32'h0000_0008, 32'h0, 1, 0, 0, m);
    fetch(32'h0000_000C, 32'h6666_6666, 1, 0, 0, m);
    fetch(32'h0000_000C, 32'h0, 1, 0, 0, m);
    fetch(32'h0000_0004, 32'h0, 1, 0, 0, m);
    fetch(32'h0000_0008, 32'h0, 1, 0, 0, m);
    check("inst last", inst, 32'h5555_5555);
`ifdef ICACHE_STATS_EN
    check("miss_count final", miss_count, 32'd3);
    check("hit_count final", hit_count, 32'd5);
`else
    check("miss_count final", miss_count, 32'd0);
    check("hit_count final", hit_count, 32'd0);
`endif
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
